rob_wide: RTL and testbench
===========================

ROB_WIDE -- requirements
Module: rob_wide

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of entries; power of two, at least 4.
REQ-002 SHALL have parameter W, default 2, meaning allocate/commit lanes per cycle; 1 to 4.
REQ-003 SHALL have parameter NCDB, default 2, meaning number of CDB writeback ports.
REQ-004 SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-005 SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning redirect PC on exception.
REQ-006 SHALL have clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have alloc_valid  in  W  per-lane allocation request, lane 0 oldest.
REQ-008 SHALL have alloc_gnt  out  W  per-lane grant.
REQ-009 SHALL have alloc_tag  out  W*log2(DEPTH)  tag for each lane.
REQ-010 SHALL have alloc_pc  in  W*XLEN, alloc_rd  in  W*5, alloc_has_rd / alloc_is_store  in  W each, meaning per-lane payload.
REQ-011 SHALL have cdb_valid  in  NCDB, cdb_tag  in  NCDB*log2(DEPTH), cdb_result / cdb_target  in  NCDB*XLEN, cdb_exc / cdb_mispred  in  NCDB, meaning writeback.
REQ-012 SHALL have cmt_valid  out  W, cmt_rd  out  W*5, cmt_we  out  W, cmt_data  out  W*XLEN, cmt_tag  out  W*log2(DEPTH), cmt_store  out  W, meaning commit ports.
REQ-013 SHALL have flush  out  1, redirect_pc  out  XLEN, exc_pc  out  XLEN, meaning recovery.
REQ-014 SHALL have count  out  log2(DEPTH)+1, meaning occupied entries.

Function
REQ-015 SHALL keep head/tail pointers of log2(DEPTH)+1 bits, where the MSB is the wrap bit; full when indices are equal and wrap bits differ, empty when both match.
REQ-016 SHALL grant lane i iff alloc_valid[0..i] are all 1 and free entries (DEPTH-count) exceed i, and flush is 0; grants form a contiguous prefix.
REQ-017 SHALL assign alloc_tag[i] = tail+i (mod DEPTH) combinationally; a granted entry is written valid, not ready, at the next edge; tail advances by the number of grants.
REQ-018 SHALL compute free entries from registered count only; entries freed by same-cycle commit are not reusable until the next cycle.
REQ-019 SHALL mark an entry ready on cdb_valid with matching tag when that entry is valid, capturing result, target, exc and mispred at the next edge; a CDB hit on an invalid entry is ignored.
REQ-020 SHALL give the higher-numbered CDB port priority when two ports hit the same tag in one cycle.
REQ-021 SHALL examine entries head..head+W-1 in order; lane k commits iff lanes 0..k-1 commit, entry k is valid and ready, and no earlier lane flushes.
REQ-022 SHALL NOT commit an excepting entry: it asserts flush, sets redirect_pc=TRAP_VEC and exc_pc=entry pc; younger lanes are suppressed.
REQ-023 SHALL commit a mispredicted entry (cmt_we=has_rd, cmt_data=result), then assert flush with redirect_pc=target and suppress younger lanes.
REQ-024 SHALL drive cmt_data=result, cmt_tag=index and cmt_store=is_store for normal commits; head advances by the commit count.
REQ-025 SHALL drive flush combinationally in the cycle the flushing entry reaches its lane; at that edge all entries are invalidated, head=tail=0, count=0, and allocations in that cycle are not granted.
REQ-026 SHALL update count as count + grants - commits each cycle, with no overflow past DEPTH or underflow below 0.
REQ-027 SHALL drive cmt_* = 0 when cmt_valid is 0 for that lane, and redirect_pc/exc_pc = 0 when flush is 0.
REQ-028 SHALL handle pointer wrap: lanes straddling index DEPTH-1 to 0 SHALL allocate and commit correctly.

Reset
REQ-029 SHALL, on rst, clear all valid bits, head=tail=0, count=0; all outputs 0 except alloc_gnt, which follows REQ-016 with count=0.
REQ-030 SHALL have rst override flush, allocation, CDB and commit in the same cycle; rst mid-stream discards all in-flight entries.

Verification (DEPTH=8, W=2, NCDB=2)
REQ-031 SHALL cover: allocate 2 per cycle for 4 cycles -> tags 0/1, 2/3, 4/5, 6/7; count=8; then alloc_gnt=00.
REQ-032 SHALL cover: tags 0,1 allocated; CDB completes tag 1, then tag 0 -> no commit until tag 0 ready, then cmt_valid=11 in one cycle with tags 0,1.
REQ-033 SHALL cover: tag 0 completes with cdb_mispred=1, target 0x80 -> cmt_valid=01, flush=1, redirect_pc=0x80; next cycle count=0 and tag 1 is not committed.
REQ-034 SHALL cover: tag 0 completes with exc=1, pc 0x40 -> cmt_valid=00, flush=1, redirect_pc=0x100, exc_pc=0x40.
REQ-035 SHALL cover: head=7 with tags 7,0 ready -> both commit in one cycle; head wraps to 1 with wrap bit toggled.
REQ-036 SHALL cover: full ROB, commit 2 and request 2 in the same cycle -> alloc_gnt=00 that cycle; next cycle grants 11.

Source files
------------

// File: rtl/rob_wide.sv
// rob_wide: W-wide reorder buffer with CDB writeback, in-order commit and flush recovery
// Ports: alloc_* allocate up to W entries per cycle (lane 0 oldest), cdb_* write back results,
// cmt_* commit up to W entries per cycle, flush/redirect_pc/exc_pc signal recovery, count = occupancy.
module rob_wide #(
    parameter int DEPTH = 16,
    parameter int W = 2,
    parameter int NCDB = 2,
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [W-1:0]                    alloc_valid,
    output logic [W-1:0]                    alloc_gnt,
    output logic [W*$clog2(DEPTH)-1:0]      alloc_tag,
    input  logic [W*XLEN-1:0]               alloc_pc,
    input  logic [W*5-1:0]                  alloc_rd,
    input  logic [W-1:0]                    alloc_has_rd,
    input  logic [W-1:0]                    alloc_is_store,
    input  logic [NCDB-1:0]                 cdb_valid,
    input  logic [NCDB*$clog2(DEPTH)-1:0]   cdb_tag,
    input  logic [NCDB*XLEN-1:0]            cdb_result,
    input  logic [NCDB*XLEN-1:0]            cdb_target,
    input  logic [NCDB-1:0]                 cdb_exc,
    input  logic [NCDB-1:0]                 cdb_mispred,
    output logic [W-1:0]                    cmt_valid,
    output logic [W*5-1:0]                  cmt_rd,
    output logic [W-1:0]                    cmt_we,
    output logic [W*XLEN-1:0]               cmt_data,
    output logic [W*$clog2(DEPTH)-1:0]      cmt_tag,
    output logic [W-1:0]                    cmt_store,
    output logic                            flush,
    output logic [XLEN-1:0]                 redirect_pc,
    output logic [XLEN-1:0]                 exc_pc,
    output logic [$clog2(DEPTH):0]          count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d, exc_q, exc_d;
    logic [DEPTH-1:0] mis_q, mis_d, hrd_q, hrd_d, st_q, st_d;
    logic [4:0]      rd_q [DEPTH];
    logic [4:0]      rd_d [DEPTH];
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] pc_d [DEPTH];
    logic [XLEN-1:0] res_q [DEPTH];
    logic [XLEN-1:0] res_d [DEPTH];
    logic [XLEN-1:0] tgt_q [DEPTH];
    logic [XLEN-1:0] tgt_d [DEPTH];
    logic [CW-1:0]   head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [CW-1:0]   n_cmt, n_gnt, free;
    logic [AW-1:0]   idx, tg, ct, base;
    logic            go;

    assign count = rst ? '0 : count_q;

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        exc_d = exc_q;
        mis_d = mis_q;
        hrd_d = hrd_q;
        st_d = st_q;
        rd_d = rd_q;
        pc_d = pc_q;
        res_d = res_q;
        tgt_d = tgt_q;
        cmt_valid = '0;
        cmt_rd = '0;
        cmt_we = '0;
        cmt_data = '0;
        cmt_tag = '0;
        cmt_store = '0;
        flush = 1'b0;
        redirect_pc = '0;
        exc_pc = '0;
        n_cmt = '0;
        n_gnt = '0;
        alloc_gnt = '0;
        alloc_tag = '0;
        idx = '0;
        tg = '0;
        ct = '0;
        // Outputs behave as if the buffer were empty while rst is held.
        go = !rst;
        for (int k = 0; k < W; k++) begin
            idx = head_q[AW-1:0] + AW'(k);
            if (go && valid_q[idx] && ready_q[idx]) begin
                if (exc_q[idx]) begin
                    flush = 1'b1;
                    redirect_pc = TRAP_VEC;
                    exc_pc = pc_q[idx];
                    go = 1'b0;
                end else begin
                    cmt_valid[k] = 1'b1;
                    cmt_rd[k*5 +: 5] = rd_q[idx];
                    cmt_we[k] = hrd_q[idx];
                    cmt_data[k*XLEN +: XLEN] = res_q[idx];
                    cmt_tag[k*AW +: AW] = idx;
                    cmt_store[k] = st_q[idx];
                    valid_d[idx] = 1'b0;
                    n_cmt = n_cmt + CW'(1);
                    if (mis_q[idx]) begin
                        flush = 1'b1;
                        redirect_pc = tgt_q[idx];
                        go = 1'b0;
                    end
                end
            end else begin
                go = 1'b0;
            end
        end
        // Higher-numbered ports are applied last so they win on a tag collision.
        for (int p = 0; p < NCDB; p++) begin
            ct = cdb_tag[p*AW +: AW];
            if (cdb_valid[p] && valid_q[ct]) begin
                ready_d[ct] = 1'b1;
                res_d[ct] = cdb_result[p*XLEN +: XLEN];
                tgt_d[ct] = cdb_target[p*XLEN +: XLEN];
                exc_d[ct] = cdb_exc[p];
                mis_d[ct] = cdb_mispred[p];
            end
        end
        // Free space comes from registered count only, so same-cycle commits are not reused.
        free = CW'(DEPTH) - (rst ? '0 : count_q);
        base = rst ? '0 : tail_q[AW-1:0];
        go = !flush;
        for (int i = 0; i < W; i++) begin
            tg = base + AW'(i);
            alloc_tag[i*AW +: AW] = tg;
            if (go && alloc_valid[i] && free > CW'(i)) begin
                alloc_gnt[i] = 1'b1;
                n_gnt = n_gnt + CW'(1);
                valid_d[tg] = 1'b1;
                ready_d[tg] = 1'b0;
                exc_d[tg] = 1'b0;
                mis_d[tg] = 1'b0;
                hrd_d[tg] = alloc_has_rd[i];
                st_d[tg] = alloc_is_store[i];
                rd_d[tg] = alloc_rd[i*5 +: 5];
                pc_d[tg] = alloc_pc[i*XLEN +: XLEN];
            end else begin
                go = 1'b0;
            end
        end
        head_d = head_q + n_cmt;
        tail_d = tail_q + n_gnt;
        count_d = count_q + n_gnt - n_cmt;
        if (flush) begin
            valid_d = '0;
            head_d = '0;
            tail_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        exc_q <= exc_d;
        mis_q <= mis_d;
        hrd_q <= hrd_d;
        st_q <= st_d;
        rd_q <= rd_d;
        pc_q <= pc_d;
        res_q <= res_d;
        tgt_q <= tgt_d;
    end
endmodule

// File: tb/tb_rob_wide.sv
// tb_rob_wide: directed table and sequences plus random traffic checked against a queue model
module tb_rob_wide;
    localparam int DEPTH = 8, W = 2, NCDB = 2, XLEN = 32, AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] alloc_valid, alloc_gnt, alloc_has_rd, alloc_is_store;
    logic [W*AW-1:0] alloc_tag;
    logic [W*XLEN-1:0] alloc_pc;
    logic [W*5-1:0] alloc_rd;
    logic [NCDB-1:0] cdb_valid, cdb_exc, cdb_mispred;
    logic [NCDB*AW-1:0] cdb_tag;
    logic [NCDB*XLEN-1:0] cdb_result, cdb_target;
    logic [W-1:0] cmt_valid, cmt_we, cmt_store;
    logic [W*5-1:0] cmt_rd;
    logic [W*XLEN-1:0] cmt_data;
    logic [W*AW-1:0] cmt_tag;
    logic flush;
    logic [XLEN-1:0] redirect_pc, exc_pc;
    logic [AW:0] count;

    rob_wide #(.DEPTH(DEPTH), .W(W), .NCDB(NCDB), .XLEN(XLEN), .TRAP_VEC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .alloc_pc(alloc_pc), .alloc_rd(alloc_rd), .alloc_has_rd(alloc_has_rd), .alloc_is_store(alloc_is_store),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result), .cdb_target(cdb_target),
        .cdb_exc(cdb_exc), .cdb_mispred(cdb_mispred),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_we(cmt_we), .cmt_data(cmt_data),
        .cmt_tag(cmt_tag), .cmt_store(cmt_store),
        .flush(flush), .redirect_pc(redirect_pc), .exc_pc(exc_pc), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        logic [31:0] pc, res, tgt;
        logic [4:0] rd;
        bit hrd, st, rdy, exc, mis;
    } ent_t;

    typedef struct {
        logic [1:0] av;
        logic [1:0] gnt;
        logic [5:0] tag;
        logic [3:0] cnt;
    } vec_t;

    ent_t q[$];
    int mtail = 0;
    int checks = 0;
    int errors = 0;
    int n_c, n_g;
    logic [W-1:0] e_gnt, e_cv, e_we, e_st;
    logic [W*AW-1:0] e_tag, e_ctag;
    logic [W*5-1:0] e_rd;
    logic [W*XLEN-1:0] e_data;
    logic e_flush;
    logic [XLEN-1:0] e_redir, e_exc;
    logic [AW:0] e_count;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic predict();
        int n;
        int b;
        bit go;
        n = rst ? 0 : q.size();
        b = rst ? 0 : mtail;
        go = !rst;
        e_gnt = '0; e_cv = '0; e_we = '0; e_st = '0; e_tag = '0; e_ctag = '0;
        e_rd = '0; e_data = '0; e_flush = 0; e_redir = '0; e_exc = '0;
        e_count = (AW+1)'(n);
        n_c = 0;
        n_g = 0;
        for (int k = 0; k < W; k++) begin
            if (go && k < n) begin
                if (!q[k].rdy) go = 0;
                else if (q[k].exc) begin
                    e_flush = 1; e_redir = 32'h100; e_exc = q[k].pc; go = 0;
                end else begin
                    e_cv[k] = 1; e_we[k] = q[k].hrd; e_st[k] = q[k].st;
                    e_rd[k*5 +: 5] = q[k].rd;
                    e_data[k*XLEN +: XLEN] = q[k].res;
                    e_ctag[k*AW +: AW] = AW'(q[k].tag);
                    n_c++;
                    if (q[k].mis) begin
                        e_flush = 1; e_redir = q[k].tgt; go = 0;
                    end
                end
            end else go = 0;
        end
        go = !e_flush;
        for (int i = 0; i < W; i++) begin
            e_tag[i*AW +: AW] = AW'((b + i) % DEPTH);
            if (go && alloc_valid[i] && (DEPTH - n) > i) begin
                e_gnt[i] = 1;
                n_g++;
            end else go = 0;
        end
    endtask

    task automatic update();
        ent_t e;
        if (rst || e_flush) begin
            q.delete();
            mtail = 0;
        end else begin
            for (int p = 0; p < NCDB; p++)
                for (int j = 0; j < q.size(); j++)
                    if (cdb_valid[p] && q[j].tag == int'(cdb_tag[p*AW +: AW])) begin
                        q[j].rdy = 1;
                        q[j].res = cdb_result[p*XLEN +: XLEN];
                        q[j].tgt = cdb_target[p*XLEN +: XLEN];
                        q[j].exc = cdb_exc[p];
                        q[j].mis = cdb_mispred[p];
                    end
            repeat (n_c) void'(q.pop_front());
            for (int i = 0; i < n_g; i++) begin
                e.tag = (mtail + i) % DEPTH;
                e.pc = alloc_pc[i*XLEN +: XLEN];
                e.rd = alloc_rd[i*5 +: 5];
                e.hrd = alloc_has_rd[i];
                e.st = alloc_is_store[i];
                e.rdy = 0; e.exc = 0; e.mis = 0; e.res = '0; e.tgt = '0;
                q.push_back(e);
            end
            mtail = (mtail + n_g) % DEPTH;
        end
    endtask

    task automatic cycle();
        #1;
        predict();
        chk("gnt", 64'(alloc_gnt), 64'(e_gnt));
        chk("alloc_tag", 64'(alloc_tag), 64'(e_tag));
        chk("cmt_valid", 64'(cmt_valid), 64'(e_cv));
        chk("cmt_rd", 64'(cmt_rd), 64'(e_rd));
        chk("cmt_we", 64'(cmt_we), 64'(e_we));
        chk("cmt_data", 64'(cmt_data), 64'(e_data));
        chk("cmt_tag", 64'(cmt_tag), 64'(e_ctag));
        chk("cmt_store", 64'(cmt_store), 64'(e_st));
        chk("flush", 64'(flush), 64'(e_flush));
        chk("redirect_pc", 64'(redirect_pc), 64'(e_redir));
        chk("exc_pc", 64'(exc_pc), 64'(e_exc));
        chk("count", 64'(count), 64'(e_count));
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic idle();
        alloc_valid = '0; alloc_pc = {$urandom, $urandom}; alloc_rd = 10'($urandom);
        alloc_has_rd = 2'($urandom); alloc_is_store = 2'($urandom);
        cdb_valid = '0; cdb_tag = '0; cdb_result = '0; cdb_target = '0; cdb_exc = '0; cdb_mispred = '0;
    endtask

    task automatic set_cdb(input int p, input int t, input logic [31:0] r, input logic [31:0] g,
                           input bit x, input bit m);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*AW +: AW] = AW'(t);
        cdb_result[p*XLEN +: XLEN] = r;
        cdb_target[p*XLEN +: XLEN] = g;
        cdb_exc[p] = x;
        cdb_mispred[p] = m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cycle();
        rst = 1'b0;
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{2'b11, 2'b11, 6'o10, 4'd0};
        tbl[1] = '{2'b11, 2'b11, 6'o32, 4'd2};
        tbl[2] = '{2'b11, 2'b11, 6'o54, 4'd4};
        tbl[3] = '{2'b11, 2'b11, 6'o76, 4'd6};
        tbl[4] = '{2'b11, 2'b00, 6'o10, 4'd8};
        idle();
        alloc_valid = 2'b01;
        #1;
        chk("rst_gnt", 64'(alloc_gnt), 64'h1);
        chk("rst_count", 64'(count), 64'h0);
        cycle();
        rst = 1'b0;
        foreach (tbl[v]) begin
            idle();
            alloc_valid = tbl[v].av;
            #1;
            chk("tbl_gnt", 64'(alloc_gnt), 64'(tbl[v].gnt));
            chk("tbl_tag", 64'(alloc_tag), 64'(tbl[v].tag));
            chk("tbl_count", 64'(count), 64'(tbl[v].cnt));
            cycle();
        end
        idle();
        set_cdb(0, 0, 32'h10, 0, 0, 0);
        set_cdb(1, 1, 32'h11, 0, 0, 0);
        cycle();
        idle();
        alloc_valid = 2'b11;
        #1;
        chk("full_gnt", 64'(alloc_gnt), 64'h0);
        chk("full_cmt", 64'(cmt_valid), 64'h3);
        cycle();
        idle();
        alloc_valid = 2'b11;
        #1;
        chk("refill_gnt", 64'(alloc_gnt), 64'h3);
        chk("refill_count", 64'(count), 64'h6);
        cycle();
        idle(); set_cdb(0, 2, 32'h12, 0, 0, 0); set_cdb(1, 3, 32'h13, 0, 0, 0); cycle();
        idle(); set_cdb(0, 4, 32'h14, 0, 0, 0); set_cdb(1, 5, 32'h15, 0, 0, 0); cycle();
        idle(); set_cdb(0, 6, 32'h16, 0, 0, 0); set_cdb(1, 0, 32'h20, 0, 0, 0); cycle();
        idle(); set_cdb(0, 7, 32'h17, 0, 0, 0); cycle();
        idle();
        #1;
        chk("wrap_cmt", 64'(cmt_valid), 64'h3);
        chk("wrap_tag", 64'(cmt_tag), 64'o07);
        cycle();
        idle(); set_cdb(1, 1, 32'h21, 0, 0, 0); cycle();
        idle();
        #1;
        chk("wrap_count", 64'(count), 64'h1);
        chk("wrap_tag1", 64'(cmt_tag), 64'h1);
        cycle();
        do_reset();
        idle(); alloc_valid = 2'b11; cycle();
        idle(); set_cdb(0, 1, 32'hAAAA, 0, 0, 0); set_cdb(1, 1, 32'hBBBB, 0, 0, 0); cycle();
        idle(); set_cdb(0, 0, 32'h1111, 0, 0, 0);
        #1;
        chk("ooo_wait", 64'(cmt_valid), 64'h0);
        cycle();
        idle();
        #1;
        chk("ooo_cmt", 64'(cmt_valid), 64'h3);
        chk("ooo_tag", 64'(cmt_tag), 64'o10);
        chk("ooo_data", 64'(cmt_data), {32'hBBBB, 32'h1111});
        cycle();
        do_reset();
        idle(); alloc_valid = 2'b11; alloc_has_rd = 2'b11; cycle();
        idle(); set_cdb(0, 0, 32'h5, 32'h80, 0, 1); set_cdb(1, 1, 32'h6, 0, 0, 0); cycle();
        idle(); alloc_valid = 2'b11;
        #1;
        chk("mis_cmt", 64'(cmt_valid), 64'h1);
        chk("mis_flush", 64'(flush), 64'h1);
        chk("mis_redir", 64'(redirect_pc), 64'h80);
        chk("mis_gnt", 64'(alloc_gnt), 64'h0);
        cycle();
        idle();
        #1;
        chk("mis_count", 64'(count), 64'h0);
        chk("mis_nocmt", 64'(cmt_valid), 64'h0);
        cycle();
        do_reset();
        idle(); alloc_valid = 2'b11; alloc_pc = {32'h44, 32'h40}; cycle();
        idle(); set_cdb(0, 0, 32'h0, 32'h0, 1, 0); cycle();
        idle();
        #1;
        chk("exc_cmt", 64'(cmt_valid), 64'h0);
        chk("exc_flush", 64'(flush), 64'h1);
        chk("exc_redir", 64'(redirect_pc), 64'h100);
        chk("exc_pc", 64'(exc_pc), 64'h40);
        cycle();
        idle();
        #1;
        chk("exc_count", 64'(count), 64'h0);
        cycle();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(99) == 0);
            alloc_valid = 2'($urandom);
            for (int p = 0; p < NCDB; p++)
                if ($urandom_range(1) == 1)
                    set_cdb(p, (q.size() > 0 && $urandom_range(7) != 0) ? q[$urandom_range(q.size() - 1)].tag
                                                                         : int'($urandom_range(7)),
                            $urandom, $urandom, $urandom_range(39) == 0, $urandom_range(24) == 0);
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
